// File: rtl/piso_pkg.sv
// Shared types and constants for the piso_stream serializer.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int STUFF_RUN_LEN = 6;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/piso_stream_if.sv
// Parallel word input and serial bit output of piso_stream, grouped as one bundle.
interface piso_stream_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_last;
  logic                  in_ready;
  logic                  ser_out;
  logic                  ser_valid;
  logic                  ser_last;
  logic                  ser_stuff;
  logic                  busy;

  modport master (
    output in_data, in_valid, in_last,
    input  in_ready, ser_out, ser_valid, ser_last, ser_stuff, busy
  );

  modport slave (
    input  in_data, in_valid, in_last,
    output in_ready, ser_out, ser_valid, ser_last, ser_stuff, busy
  );
endinterface

// File: rtl/piso_fifo.sv
// Synchronous DEPTH-entry word buffer with full/empty/count; read data is the head entry.
module piso_fifo #(
  parameter  int WIDTH = 9,
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // NOTE: storage has no reset; an entry is never read before the count says it was written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/piso_stream.sv
// Buffered parallel-in/serial-out serializer, one bit per clk with gap-free word chaining.
// Optional HDLC-style zero insertion after a run of ones: define PISO_BIT_STUFF_EN.
module piso_stream
  import piso_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 2,
  parameter bit MSB_FIRST  = 1'b0
) (
  input logic          clk,
  input logic          rst,
  piso_stream_if.slave bus
);
  localparam int CNT_W  = cnt_width(DATA_WIDTH);
  localparam int FCNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
  logic                  last_q, last_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  in_ready_q, in_ready_d;
  logic                  push, load, ser_bit, stuff_q;
  logic [DATA_WIDTH:0]   fifo_rdata;
  logic                  fifo_full, fifo_empty;
  logic [FCNT_W-1:0]     fifo_count, fifo_count_next;

  assign push = bus.in_valid && in_ready_q && !fifo_full;

  piso_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push),
    .wdata_i ({bus.in_last, bus.in_data}),
    .pop_i   (load),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // in_ready looks at the post-edge occupancy, so a pop never opens a slot in the same cycle.
  assign fifo_count_next = fifo_count + FCNT_W'(push) - FCNT_W'(load);
  assign in_ready_d      = (fifo_count_next != FCNT_W'(DEPTH));

  assign ser_bit = MSB_FIRST ? sreg_q[DATA_WIDTH-1] : sreg_q[0];

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    state_d = state_q;
    sreg_d  = sreg_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    case (state_q)
      IDLE: load = !fifo_empty && !stuff_q;
      SHIFT: begin
        if (!stuff_q) begin
          if (cnt_q == LAST_BIT) begin
            load = !fifo_empty;
            if (fifo_empty) state_d = IDLE;
          end else begin
            sreg_d = MSB_FIRST ? {sreg_q[DATA_WIDTH-2:0], 1'b0}
                               : {1'b0, sreg_q[DATA_WIDTH-1:1]};
            cnt_d  = cnt_q + CNT_W'(1);
          end
        end
      end
    endcase
    if (load) begin
      state_d          = SHIFT;
      {last_d, sreg_d} = fifo_rdata;
      cnt_d            = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sreg_q     <= '0;
      last_q     <= 1'b0;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
    end
  end

`ifdef PISO_BIT_STUFF_EN
  localparam int RUN_W = cnt_width(STUFF_RUN_LEN + 1);
  logic [RUN_W-1:0] run_q, run_d;
  logic             stuff_d;

  // A stuff cycle holds the shifter; the run restarts after the inserted zero.
  always_comb begin
    run_d   = '0;
    stuff_d = 1'b0;
    if (state_q == SHIFT && !stuff_q && ser_bit) begin
      if (run_q == RUN_W'(STUFF_RUN_LEN - 1)) stuff_d = 1'b1;
      else                                    run_d   = run_q + RUN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q   <= '0;
      stuff_q <= 1'b0;
    end else begin
      run_q   <= run_d;
      stuff_q <= stuff_d;
    end
  end
`else
  assign stuff_q = 1'b0;
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.ser_valid = (state_q == SHIFT) || stuff_q;
  assign bus.ser_out   = (state_q == SHIFT) && !stuff_q && ser_bit;
  assign bus.ser_last  = (state_q == SHIFT) && !stuff_q && last_q && (cnt_q == LAST_BIT);
  assign bus.ser_stuff = stuff_q;
  assign bus.busy      = !fifo_empty || (state_q == SHIFT);
endmodule

// File: tb/tb_piso_stream.sv
// Directed bench for piso_stream: an LSB-first and an MSB-first instance, 8-bit words, DEPTH=2.
module tb_piso_stream;
  typedef struct {
    int         sel;
    logic [7:0] data;
    logic       last;
    logic [7:0] exp_seq;  // bit i = i-th serial bit emitted
  } vec_t;

  typedef struct {
    logic b;
    logic l;
    logic s;
    int   c;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   stall_cnt = 0;
  rec_t q0[$];
  rec_t q1[$];
  vec_t vecs[5];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  piso_stream_if #(.DATA_WIDTH(8)) if0 ();
  piso_stream_if #(.DATA_WIDTH(8)) if1 ();

  piso_stream #(.DATA_WIDTH(8), .DEPTH(2), .MSB_FIRST(1'b0)) dut0 (
    .clk (clk), .rst (rst), .bus (if0.slave)
  );
  piso_stream #(.DATA_WIDTH(8), .DEPTH(2), .MSB_FIRST(1'b1)) dut1 (
    .clk (clk), .rst (rst), .bus (if1.slave)
  );

  always @(negedge clk) begin
    if (if0.ser_valid) q0.push_back('{b: if0.ser_out, l: if0.ser_last, s: if0.ser_stuff, c: cyc});
    if (if1.ser_valid) q1.push_back('{b: if1.ser_out, l: if1.ser_last, s: if1.ser_stuff, c: cyc});
    if (if0.in_valid && !if0.in_ready && !rst) stall_cnt <= stall_cnt + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 0) ? if0.in_ready : if1.in_ready;
  endfunction

  function automatic logic is_busy(input int sel);
    return (sel == 0) ? if0.busy : if1.busy;
  endfunction

  function automatic logic [5:0] outs(input int sel);
    if (sel == 0) return {if0.in_ready, if0.ser_valid, if0.ser_out, if0.ser_last, if0.ser_stuff, if0.busy};
    return {if1.in_ready, if1.ser_valid, if1.ser_out, if1.ser_last, if1.ser_stuff, if1.busy};
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge with in_valid low.
  task automatic push(input int sel, input logic [7:0] d, input logic l);
    int n = 0;
    if (sel == 0) begin if0.in_data = d; if0.in_last = l; if0.in_valid = 1'b1; end
    else          begin if1.in_data = d; if1.in_last = l; if1.in_valid = 1'b1; end
    while (!rdy(sel) && n < 100) begin @(negedge clk); n++; end
    if (!rdy(sel)) check("ready_timeout", rdy(sel), 1);
    @(posedge clk);
    @(negedge clk);
    acc_cyc = cyc;
    if (sel == 0) if0.in_valid = 1'b0;
    else          if1.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int sel, output int fall);
    int n = 0;
    while (is_busy(sel) && n < 300) begin @(negedge clk); n++; end
    if (is_busy(sel)) check("idle_timeout", is_busy(sel), 0);
    fall = cyc;
  endtask

  task automatic get_masks(input int sel, output logic [63:0] bv, output logic [63:0] lv,
                           output logic [63:0] sv, output int n, output int c0, output int cl);
    rec_t q[$];
    if (sel == 0) q = q0;
    else          q = q1;
    bv = '0; lv = '0; sv = '0; c0 = 0; cl = 0;
    n = q.size();
    for (int i = 0; i < n && i < 64; i++) begin
      bv[i] = q[i].b;
      lv[i] = q[i].l;
      sv[i] = q[i].s;
    end
    if (n > 0) begin c0 = q[0].c; cl = q[n-1].c; end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int fall, n, c0, cl;
    logic [63:0] bv, lv, sv;
    if (v.sel == 0) q0.delete();
    else            q1.delete();
    push(v.sel, v.data, v.last);
    wait_idle(v.sel, fall);
    get_masks(v.sel, bv, lv, sv, n, c0, cl);
    check({tag, "_nbits"}, n, 8);
    check({tag, "_bits"}, bv, {56'h0, v.exp_seq});
    check({tag, "_last"}, lv, v.last ? 64'h80 : 64'h0);
    check({tag, "_stuff"}, sv, 0);
    check({tag, "_latency"}, c0 - acc_cyc, 1);
    check({tag, "_busy_fall"}, fall - cl, 1);
  endtask

  initial begin
    int fall, n, c0, cl;
    logic [63:0] bv, lv, sv;
    logic [7:0] words[5];
    vec_t v;

    vecs[0] = '{sel: 0, data: 8'hA5, last: 1'b0, exp_seq: 8'hA5};
    vecs[1] = '{sel: 0, data: 8'h0F, last: 1'b1, exp_seq: 8'h0F};
    vecs[2] = '{sel: 1, data: 8'hC3, last: 1'b0, exp_seq: 8'hC3};
    vecs[3] = '{sel: 1, data: 8'h80, last: 1'b1, exp_seq: 8'h01};
    vecs[4] = '{sel: 1, data: 8'h0F, last: 1'b0, exp_seq: 8'hF0};
    words   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    if0.in_data = '0; if0.in_valid = 1'b0; if0.in_last = 1'b0;
    if1.in_data = '0; if1.in_valid = 1'b0; if1.in_last = 1'b0;

    // Reset state, then in_ready rises one edge after rst falls.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outs_lsb", outs(0), 6'b0);
    check("reset_outs_msb", outs(1), 6'b0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {if0.in_ready, if1.in_ready, if0.busy}, 3'b110);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back words must chain with no gap bit.
    q0.delete();
    push(0, 8'h01, 1'b0);
    push(0, 8'h80, 1'b1);
    wait_idle(0, fall);
    get_masks(0, bv, lv, sv, n, c0, cl);
    check("b2b_nbits", n, 16);
    check("b2b_bits", bv, 64'h8001);
    check("b2b_last", lv, 64'h8000);
    check("b2b_contiguous", cl - c0, 15);

    // Five words held against a two-entry buffer.
    q0.delete();
    stall_cnt = 0;
    for (int i = 0; i < 5; i++) push(0, words[i], i == 4);
    wait_idle(0, fall);
    get_masks(0, bv, lv, sv, n, c0, cl);
    check("bp_nbits", n, 40);
    for (int i = 0; i < 5; i++) check($sformatf("bp_word%0d", i), bv[8*i +: 8], words[i]);
    check("bp_last", lv, 64'h80_0000_0000);
    check("bp_contiguous", cl - c0, 39);
    check("bp_stall_seen", stall_cnt > 0, 1);

    // Reset in the middle of a word with a second word queued.
    q0.delete();
    push(0, 8'hFF, 1'b0);
    push(0, 8'hFF, 1'b1);
    n = 0;
    while (q0.size() < 3 && n < 100) begin @(negedge clk); n++; end
    check("rstmid_progress", q0.size() >= 3, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_outs_zero", outs(0), 6'b0);
    rst = 1'b0;
    q0.delete();
    @(negedge clk);
    check("rstmid_ready_back", if0.in_ready, 1);
    repeat (20) @(negedge clk);
    check("rstmid_no_bits", q0.size(), 0);
    v = '{sel: 0, data: 8'h0F, last: 1'b0, exp_seq: 8'h0F};
    run_vec(v, "rstmid_fresh");

    // Two all-ones words: zero insertion only when the feature is built in.
    q0.delete();
    push(0, 8'hFF, 1'b0);
    push(0, 8'hFF, 1'b1);
    wait_idle(0, fall);
    get_masks(0, bv, lv, sv, n, c0, cl);
`ifdef PISO_BIT_STUFF_EN
    check("ones_nbits", n, 18);
    check("ones_bits", bv, 64'h3_DFBF);
    check("ones_stuff", sv, 64'h0_2040);
    check("ones_last", lv, 64'h2_0000);
    check("ones_contiguous", cl - c0, 17);
`else
    check("ones_nbits", n, 16);
    check("ones_bits", bv, 64'hFFFF);
    check("ones_stuff", sv, 64'h0);
    check("ones_last", lv, 64'h8000);
    check("ones_contiguous", cl - c0, 15);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/piso_stream.md
Name: piso_stream

Overview:
Parametrised parallel-in/serial-out serializer with a valid/ready input handshake, a DEPTH-entry word buffer and gap-free back-to-back shifting. Configurable word width and bit order; carries an end-of-packet marker through to the serial side. Sits between the hub's packet assembly logic and the line encoder, driving one serial bit per clk.

Parameters:
DATA_WIDTH, 8, bits per parallel word (>=2)
DEPTH, 2, buffer entries ahead of the shifter (power of 2, >=2)
MSB_FIRST, 0, 0 = LSB shifted first, 1 = MSB first

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
in_data  in  DATA_WIDTH  parallel word
in_valid  in  1  in_data/in_last valid
in_last  in  1  word is the last of a packet
in_ready  out  1  buffer can accept a word this cycle
ser_out  out  1  serial data bit
ser_valid  out  1  ser_out carries a real bit
ser_last  out  1  final bit of a word tagged in_last
ser_stuff  out  1  current bit is an inserted stuff bit (0 when feature off)
busy  out  1  buffer non-empty or shifter active

Behaviour:
- Reset (sync, rst high at edge): buffer emptied, shifter IDLE, bit counter 0; all outputs 0 in the following cycle, including in_ready. in_ready rises the cycle after rst falls.
- Accept: word + last flag written when in_valid && in_ready at rising edge. in_ready = !full, registered; no write while full even if a pop occurs the same edge (accepted conservatism, costs one cycle).
- States: IDLE, SHIFT. IDLE -> SHIFT when buffer non-empty: word popped into shift register. SHIFT -> IDLE after final bit when buffer empty; if buffer non-empty at final bit, next word loaded on the same edge (no gap bit).
- Latency: word accepted at edge N into empty block -> first bit on ser_out/ser_valid during cycle after edge N+1; DATA_WIDTH contiguous bits follow.
- Bit order: MSB_FIRST=0 -> bit 0 first; MSB_FIRST=1 -> bit DATA_WIDTH-1 first.
- Bit counter: $clog2(DATA_WIDTH) bits, 0..DATA_WIDTH-1, wraps to 0 on word load; no overflow past DATA_WIDTH-1.
- ser_last high only during last data bit of an in_last word; never on a stuff bit.
- ser_out driven 0 whenever ser_valid is 0.
- busy = buffer non-empty || state==SHIFT.
- Buffer pointers wrap modulo DEPTH; count width $clog2(DEPTH)+1; simultaneous push and pop when neither full nor empty keeps count unchanged.
- Reset mid-word: current and buffered words discarded, no partial bits emitted after reset cycle.

Optional Feature:
PISO_BIT_STUFF_EN: when defined, a run counter tracks consecutive 1 bits on ser_out; after the 6th consecutive 1, the next cycle emits a 0 with ser_valid=1, ser_stuff=1, shifter and bit counter stalled one cycle, run counter cleared. Run counter clears on any 0 bit and on IDLE; persists across back-to-back words. in_ready unaffected except through buffer occupancy. When undefined: no run counter, no insertion, ser_stuff tied 0.

Decomposition:
- Package piso_pkg: state enum (IDLE, SHIFT), STUFF_RUN_LEN=6 constant, width helper for counters.
- One sub-module: piso_fifo (synchronous DEPTH x (DATA_WIDTH+1) buffer with full/empty/count); shifter FSM stays in piso_stream.

Test Plan:
- Single word, DATA_WIDTH=8, MSB_FIRST=0: push 8'hA5 -> ser_out 1,0,1,0,0,1,0,1 on 8 consecutive ser_valid cycles starting 2 edges after accept; busy drops after last bit.
- Back-to-back: push 8'h01 then 8'h80 (in_last=1) -> 16 contiguous ser_valid bits, 1,0x7,0x7,1; ser_last high only on bit 16.
- Full/backpressure, DEPTH=2: hold in_valid with 5 words -> in_ready low while 2 entries queued, no word lost or duplicated, output order preserved.
- MSB_FIRST=1: push 8'hC3 -> ser_out 1,1,0,0,0,0,1,1.
- Reset mid-word: assert rst after 3 bits of 8'hFF with 1 word queued -> all outputs 0 next cycle, no further bits; fresh push 8'h0F serialises normally.
- PISO_BIT_STUFF_EN: push 8'hFF, 8'hFF -> 18 ser_valid bits, stuffed 0 with ser_stuff=1 after data bits 6 and 12; without macro -> 16 bits of 1, ser_stuff 0.
